// File: rtl/brick_field_if.sv
// Request/response and pixel-stream bundle between the game FSM, the brick
// engine and the pixel mux. N is the brick count and sets the index/count widths.
interface brick_field_if #(
    parameter int N = 10
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic          init;
    logic          step;
    logic [7:0]    ball_x;
    logic [7:0]    ball_y;
    logic          busy;
    logic          done;
    logic          hit;
    logic [IW-1:0] hit_index;
    logic [CW-1:0] bricks_left;
    logic          plot;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [2:0]    colour;

    modport master (
        output init, step, ball_x, ball_y,
        input  busy, done, hit, hit_index, bricks_left, plot, x, y, colour
    );

    modport slave (
        input  init, step, ball_x, ball_y,
        output busy, done, hit, hit_index, bricks_left, plot, x, y, colour
    );
endinterface

// File: rtl/brick_field.sv
// Brick-array engine: keeps the alive map, scans one brick per cycle for a
// ball collision and streams registered pixel writes to draw or erase bricks.
module brick_field #(
    parameter int         ROWS         = 2,
    parameter int         COLS         = 5,
    parameter int         BRICK_W      = 8,
    parameter int         BRICK_H      = 2,
    parameter int         X0           = 15,
    parameter int         Y0           = 30,
    parameter int         PITCH_X      = 30,
    parameter int         PITCH_Y      = 6,
    parameter logic [2:0] BRICK_COLOUR = 3'b010
) (
    input logic          CLOCK_50,
    input logic          reset,
    brick_field_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int WH = BRICK_W * BRICK_H;
    localparam int PW = (WH > 1) ? $clog2(WH) : 1;

    typedef enum logic [2:0] {IDLE, DRAW, CHECK, ERASE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [PW-1:0] pix_reg, pix_next;
    logic [N-1:0]  alive_reg, alive_next;
    logic [CW-1:0] count_reg, count_next;
    logic          found_reg, found_next;
    logic [IW-1:0] win_reg, win_next;
    logic          hit_reg, hit_next;
    logic [IW-1:0] hit_index_reg, hit_index_next;
    logic [7:0]    ball_x_reg, ball_x_next;
    logic [7:0]    ball_y_reg, ball_y_next;
    logic          plot_reg, plot_next;
    logic [7:0]    x_reg, x_next;
    logic [7:0]    y_reg, y_next;
    logic [2:0]    colour_reg, colour_next;
    logic          load_pix;

    // Brick origins are elaboration-time constants; the rectangle test is
    // evaluated for every brick against the latched ball and the scan picks one.
    logic [7:0]    org_x [N];
    logic [7:0]    org_y [N];
    logic [N-1:0]  in_rect;

    for (genvar gi = 0; gi < N; gi++) begin : g_brick
        localparam int BX = X0 + (gi % COLS) * PITCH_X;
        localparam int BY = Y0 + (gi / COLS) * PITCH_Y;
        assign org_x[gi]   = 8'(BX);
        assign org_y[gi]   = 8'(BY);
        assign in_rect[gi] = (ball_x_reg >= 8'(BX)) && (ball_x_reg <= 8'(BX + BRICK_W - 1)) &&
                             (ball_y_reg >= 8'(BY)) && (ball_y_reg <= 8'(BY + BRICK_H - 1));
    end

    logic          cand;
    logic          fin_found;
    logic [IW-1:0] fin_win;

    assign cand      = alive_reg[idx_reg] & in_rect[idx_reg];
    assign fin_found = found_reg | cand;
    assign fin_win   = found_reg ? win_reg : idx_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            pix_reg       <= '0;
            alive_reg     <= '0;
            count_reg     <= '0;
            found_reg     <= 1'b0;
            win_reg       <= '0;
            hit_reg       <= 1'b0;
            hit_index_reg <= '0;
            ball_x_reg    <= '0;
            ball_y_reg    <= '0;
            plot_reg      <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            colour_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            pix_reg       <= pix_next;
            alive_reg     <= alive_next;
            count_reg     <= count_next;
            found_reg     <= found_next;
            win_reg       <= win_next;
            hit_reg       <= hit_next;
            hit_index_reg <= hit_index_next;
            ball_x_reg    <= ball_x_next;
            ball_y_reg    <= ball_y_next;
            plot_reg      <= plot_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            colour_reg    <= colour_next;
        end
    end

    // idx/pix always name the pixel that the output registers will show next
    // cycle, so the first plot appears the cycle after the request is accepted.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        pix_next       = pix_reg;
        alive_next     = alive_reg;
        count_next     = count_reg;
        found_next     = found_reg;
        win_next       = win_reg;
        hit_next       = hit_reg;
        hit_index_next = hit_index_reg;
        ball_x_next    = ball_x_reg;
        ball_y_next    = ball_y_reg;
        colour_next    = colour_reg;
        load_pix       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.init) begin
                    alive_next  = '1;
                    count_next  = CW'(N);
                    idx_next    = '0;
                    pix_next    = '0;
                    colour_next = BRICK_COLOUR;
                    hit_next    = 1'b0;
                    load_pix    = 1'b1;
                    state_next  = DRAW;
                end else if (bus.step) begin
                    ball_x_next = bus.ball_x;
                    ball_y_next = bus.ball_y;
                    idx_next    = '0;
                    found_next  = 1'b0;
                    hit_next    = 1'b0;
                    state_next  = CHECK;
                end
            end
            DRAW: begin
                load_pix = 1'b1;
                if (pix_reg == PW'(WH - 1)) begin
                    pix_next = '0;
                    if (idx_reg == IW'(N - 1)) begin
                        load_pix   = 1'b0;
                        hit_next   = 1'b0;
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end else begin
                    pix_next = pix_reg + PW'(1);
                end
            end
            CHECK: begin
                if (cand && !found_reg) begin
                    found_next = 1'b1;
                    win_next   = idx_reg;
                end
                if (idx_reg == IW'(N - 1)) begin
                    if (fin_found) begin
                        alive_next[fin_win] = 1'b0;
                        count_next          = count_reg - CW'(1);
                        hit_index_next      = fin_win;
                        idx_next            = fin_win;
                        pix_next            = '0;
                        colour_next         = 3'b000;
                        load_pix            = 1'b1;
                        state_next          = ERASE;
                    end else begin
                        hit_next   = 1'b0;
                        state_next = DONE;
                    end
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            ERASE: begin
                if (pix_reg == PW'(WH - 1)) begin
                    hit_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    pix_next = pix_reg + PW'(1);
                    load_pix = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        plot_next = load_pix;
        x_next    = load_pix ? org_x[idx_next] + 8'(int'(pix_next) % BRICK_W) : x_reg;
        y_next    = load_pix ? org_y[idx_next] + 8'(int'(pix_next) / BRICK_W) : y_reg;
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.hit         = hit_reg;
    assign bus.hit_index   = hit_index_reg;
    assign bus.bricks_left = count_reg;
    assign bus.plot        = plot_reg;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.colour      = colour_reg;
endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: a per-operation trace model (pixel lists, scan length,
// winner search) feeds a queue that a per-cycle compare process consumes.
module tb_brick_field;
    localparam int ROWS = 2, COLS = 5, BW = 8, BH = 2, X0 = 15, Y0 = 30, PX = 30, PY = 6;
    localparam int N = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brick_field_if #(.N(N)) if0 ();
    brick_field_if #(.N(N)) if1 ();

    brick_field dut (.CLOCK_50(clk), .reset(rst), .bus(if0));
    brick_field #(.PITCH_X(4)) dut2 (.CLOCK_50(clk), .reset(rst), .bus(if1));

    typedef struct {
        bit       busy, done, plot, hit;
        int       x, y, col, hidx, left;
    } rec_t;

    rec_t exp_q[$];
    bit   m_alive[N];
    int   m_left, m_x, m_y, m_col, m_hit, m_hidx;
    int   n_checks = 0, n_errors = 0;
    bit   cmp_en = 1'b0;
    int   px_x[256], px_y[256], px_c[256];
    int   r_cyc, r_plots, r_hit, r_idx, r_left;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bx_of(int i); return X0 + (i % COLS) * PX; endfunction
    function automatic int by_of(int i); return Y0 + (i / COLS) * PY; endfunction

    function automatic void push_pixels(int i, int col);
        rec_t r;
        for (int p = 0; p < BW * BH; p++) begin
            r = '{default: 0};
            r.busy = 1; r.plot = 1; r.col = col;
            r.x = bx_of(i) + p % BW; r.y = by_of(i) + p / BW;
            exp_q.push_back(r);
            m_x = r.x; m_y = r.y; m_col = col;
        end
    endfunction

    // Builds the full expected output trace of one accepted request.
    function automatic void model_push(bit i_init, bit i_step, int bx, int by);
        rec_t r;
        int   win;
        if (i_init) begin
            for (int i = 0; i < N; i++) m_alive[i] = 1;
            m_left = N;
            for (int i = 0; i < N; i++) push_pixels(i, 2);
            m_hit = 0;
        end else if (i_step) begin
            win = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_alive[i] && bx >= bx_of(i) && bx < bx_of(i) + BW &&
                    by >= by_of(i) && by < by_of(i) + BH) win = i;
            for (int i = 0; i < N; i++) begin
                r = '{default: 0};
                r.busy = 1;
                exp_q.push_back(r);
            end
            if (win >= 0) begin
                m_alive[win] = 0;
                m_left--;
                push_pixels(win, 0);
                m_hidx = win;
                m_hit  = 1;
            end else begin
                m_hit = 0;
            end
        end
        r = '{default: 0};
        r.busy = 1; r.done = 1; r.hit = (m_hit != 0); r.hidx = m_hidx; r.left = m_left;
        exp_q.push_back(r);
    endfunction

    always @(negedge clk) begin
        rec_t r;
        if (cmp_en) begin
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("busy", int'(if0.busy), int'(r.busy));
                check("done", int'(if0.done), int'(r.done));
                check("plot", int'(if0.plot), int'(r.plot));
                if (r.plot) begin
                    check("x", int'(if0.x), r.x);
                    check("y", int'(if0.y), r.y);
                    check("colour", int'(if0.colour), r.col);
                end
                if (r.done) begin
                    check("hit", int'(if0.hit), int'(r.hit));
                    check("bricks_left", int'(if0.bricks_left), r.left);
                    if (r.hit) check("hit_index", int'(if0.hit_index), r.hidx);
                end
            end else begin
                check("idle_busy", int'(if0.busy), 0);
                check("idle_done", int'(if0.done), 0);
                check("idle_plot", int'(if0.plot), 0);
                check("idle_x", int'(if0.x), m_x);
                check("idle_y", int'(if0.y), m_y);
                check("idle_colour", int'(if0.colour), m_col);
                check("idle_hit", int'(if0.hit), m_hit);
                check("idle_hit_index", int'(if0.hit_index), m_hidx);
                check("idle_bricks_left", int'(if0.bricks_left), m_left);
            end
        end
    end

    task automatic issue(input logic i_init, input logic i_step, input logic [7:0] bx, input logic [7:0] by);
        @(negedge clk);
        if0.init = i_init; if0.step = i_step; if0.ball_x = bx; if0.ball_y = by;
        @(posedge clk);
        model_push(i_init, i_step, int'(bx), int'(by));
        @(negedge clk);
        if0.init = 1'b0; if0.step = 1'b0;
    endtask

    // Entered at the sampling point of cycle 'start' after acceptance.
    task automatic wait_done(input int start);
        r_cyc = start; r_plots = 0;
        while (!if0.done && r_cyc < 400) begin
            if (if0.plot && r_plots < 256) begin
                px_x[r_plots] = int'(if0.x); px_y[r_plots] = int'(if0.y); px_c[r_plots] = int'(if0.colour);
                r_plots++;
            end
            @(negedge clk);
            r_cyc++;
        end
        check("done_seen", int'(if0.done), 1);
        r_hit = int'(if0.hit); r_idx = int'(if0.hit_index); r_left = int'(if0.bricks_left);
    endtask

    task automatic run_op(input logic i_init, input logic i_step, input logic [7:0] bx, input logic [7:0] by);
        issue(i_init, i_step, bx, by);
        wait_done(1);
        $display("op init=%0d step=%0d ball=(%0d,%0d) done_cycle=%0d plots=%0d hit=%0d hit_index=%0d bricks_left=%0d",
                 i_init, i_step, bx, by, r_cyc, r_plots, r_hit, r_idx, r_left);
    endtask

    task automatic run2(input logic i_init, input logic [7:0] bx, input logic [7:0] by);
        int cyc;
        @(negedge clk);
        if1.init = i_init; if1.step = !i_init; if1.ball_x = bx; if1.ball_y = by;
        @(negedge clk);
        if1.init = 1'b0; if1.step = 1'b0;
        cyc = 1;
        while (!if1.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("dut2_done_seen", int'(if1.done), 1);
        r_cyc = cyc; r_hit = int'(if1.hit); r_idx = int'(if1.hit_index); r_left = int'(if1.bricks_left);
        $display("dut2 op init=%0d ball=(%0d,%0d) done_cycle=%0d hit=%0d hit_index=%0d bricks_left=%0d",
                 i_init, bx, by, r_cyc, r_hit, r_idx, r_left);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.init = 0; if0.step = 0; if0.ball_x = 0; if0.ball_y = 0;
        if1.init = 0; if1.step = 0; if1.ball_x = 0; if1.ball_y = 0;
        for (int i = 0; i < N; i++) m_alive[i] = 0;
        m_left = 0; m_x = 0; m_y = 0; m_col = 0; m_hit = 0; m_hidx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) cmp_en = 1'b1;
        @(negedge clk);
        check("reset_bricks_left", int'(if0.bricks_left), 0);
        check("reset_busy", int'(if0.busy), 0);

        // Full field draw
        run_op(1, 0, 0, 0);
        check("init_done_cycle", r_cyc, 161);
        check("init_plots", r_plots, 160);
        check("init_px0_x", px_x[0], 15);   check("init_px0_y", px_y[0], 30);
        check("init_px8_x", px_x[8], 15);   check("init_px8_y", px_y[8], 31);
        check("init_last_x", px_x[159], 142); check("init_last_y", px_y[159], 37);
        check("init_last_colour", px_c[159], 2);
        check("init_left", r_left, 10);

        // Hit brick 0, then the same spot again
        run_op(0, 1, 22, 31);
        check("hit0_hit", r_hit, 1);   check("hit0_index", r_idx, 0);
        check("hit0_done_cycle", r_cyc, 27); check("hit0_plots", r_plots, 16);
        check("hit0_first_x", px_x[0], 15);  check("hit0_last_x", px_x[15], 22);
        check("hit0_last_y", px_y[15], 31);  check("hit0_colour", px_c[15], 0);
        check("hit0_left", r_left, 9);
        run_op(0, 1, 22, 31);
        check("rehit_hit", r_hit, 0); check("rehit_done_cycle", r_cyc, 11);
        check("rehit_plots", r_plots, 0);

        // Boundary misses on a fresh field
        run_op(1, 0, 0, 0);
        run_op(0, 1, 23, 30); check("miss_right", r_hit, 0);
        run_op(0, 1, 14, 30); check("miss_left", r_hit, 0);
        run_op(0, 1, 15, 32); check("miss_below", r_hit, 0);
        check("miss_left_count", r_left, 10);

        run_op(0, 1, 45, 36);
        check("b6_hit", r_hit, 1); check("b6_index", r_idx, 6); check("b6_left", r_left, 9);

        // init wins over a simultaneous step
        run_op(1, 1, 22, 31);
        check("both_done_cycle", r_cyc, 161); check("both_hit", r_hit, 0);
        check("both_left", r_left, 10);

        // Step pulsed during the scan is ignored
        issue(0, 1, 22, 31);
        if0.step = 1'b1; if0.ball_x = 45; if0.ball_y = 36;
        @(negedge clk);
        if0.step = 1'b0;
        wait_done(2);
        check("busy_step_cycle", r_cyc, 27); check("busy_step_index", r_idx, 0);
        check("busy_step_left", r_left, 9);
        repeat (5) @(negedge clk);

        // Reset in cycle 50 of a draw
        issue(1, 0, 0, 0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        for (int i = 0; i < N; i++) m_alive[i] = 0;
        m_left = 0; m_x = 0; m_y = 0; m_col = 0; m_hit = 0; m_hidx = 0;
        @(negedge clk) rst = 1'b0;
        check("midreset_plot", int'(if0.plot), 0);
        check("midreset_left", int'(if0.bricks_left), 0);
        repeat (5) @(negedge clk);
        run_op(0, 1, 22, 31);
        check("postreset_hit", r_hit, 0); check("postreset_cycle", r_cyc, 11);

        // Overlapping bricks: lowest index wins and the other stays alive
        run2(1, 0, 0);
        check("ovl_init_cycle", r_cyc, 161);
        run2(0, 20, 30);
        check("ovl_hit", r_hit, 1); check("ovl_index", r_idx, 0); check("ovl_left", r_left, 9);
        run2(0, 20, 30);
        check("ovl_second_index", r_idx, 1); check("ovl_second_left", r_left, 8);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
